// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
// The instruction decoder imports the same package so both sides agree on op values.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } mdState_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic             dividendBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic             quotBit
);

    logic [WIDTH:0] shifted;

    // remIn < divisor, so the difference always fits back into WIDTH bits.
    always_comb begin
        shifted = {remIn, dividendBit};
        quotBit = (shifted >= {1'b0, divisor});
        remOut  = quotBit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU (shift-add) and DIV/DIVU (restoring) unit owning HI/LO.
// Define MULDIV_DIVIDE_EN to build the divider; otherwise divide ops finish at once with err.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             wrHi,
    input  logic             wrLo,
    input  logic [WIDTH-1:0] wrData,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int BPC = BITS_PER_CYCLE;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / BPC - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    mdState_t state, stateNext;

    logic [CW-1:0]      cnt;
    logic               isDivReg;
    logic               negProd;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   prodHi;
    logic [WIDTH-1:0]   prodLo;
    logic               signedOp;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH+BPC-1:0] partial;
    logic [WIDTH+BPC-1:0] mulSum;
    logic [2*WIDTH-1:0] fullProd;

`ifdef MULDIV_DIVIDE_EN
    logic             negRem;
    logic             divZero;
    logic [WIDTH-1:0] rawA;
    logic [WIDTH-1:0] divRem;
    logic             divQ;

    restoring_div_step #(.WIDTH(WIDTH)) uDivStep (
        .remIn      (prodHi),
        .dividendBit(prodLo[WIDTH-1]),
        .divisor    (mcand),
        .remOut     (divRem),
        .quotBit    (divQ)
    );
`endif

    // Operands are stored as magnitudes; the sign is reapplied in FIX.
    always_comb begin
        signedOp = (op == MD_MULT) || (op == MD_DIV);
        magA     = (signedOp && opA[WIDTH-1]) ? -opA : opA;
        magB     = (signedOp && opB[WIDTH-1]) ? -opB : opB;
        fullProd = {prodHi, prodLo};
    end

    // Multiplier digit times multiplicand, built from shifted adds.
    always_comb begin
        partial = '0;
        for (int j = 0; j < BPC; j++) begin
            if (prodLo[j]) begin
                partial = partial + ({{BPC{1'b0}}, mcand} << j);
            end
        end
        mulSum = {{BPC{1'b0}}, prodHi} + partial;
    end

    always_comb begin
        stateNext = state;
        busy      = (state == MD_RUN);
        case (state)
            MD_IDLE: begin
                if (start) begin
`ifdef MULDIV_DIVIDE_EN
                    stateNext = MD_RUN;
`else
                    stateNext = op[1] ? MD_FIX : MD_RUN;
`endif
                end
            end
            MD_RUN: begin
                if (cnt == (isDivReg ? DIV_LAST : MUL_LAST)) begin
                    stateNext = MD_FIX;
                end
            end
            MD_FIX:  stateNext = MD_IDLE;
            default: stateNext = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath: prodHi/prodLo hold the product halves while multiplying and
    // the partial remainder / shifting dividend-quotient while dividing.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            isDivReg <= 1'b0;
            negProd  <= 1'b0;
            mcand    <= '0;
            prodHi   <= '0;
            prodLo   <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            negRem   <= 1'b0;
            divZero  <= 1'b0;
            rawA     <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        isDivReg <= op[1];
                        negProd  <= signedOp && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        prodHi   <= '0;
                        prodLo   <= op[1] ? magA : magB;
                        mcand    <= op[1] ? magB : magA;
`ifdef MULDIV_DIVIDE_EN
                        negRem   <= signedOp && opA[WIDTH-1];
                        divZero  <= (opB == '0);
                        rawA     <= opA;
`endif
                    end else begin
                        if (wrHi) hi <= wrData;
                        if (wrLo) lo <= wrData;
                    end
                end
                MD_RUN: begin
                    cnt <= cnt + 1'b1;
`ifdef MULDIV_DIVIDE_EN
                    if (isDivReg) begin
                        prodHi <= divRem;
                        prodLo <= {prodLo[WIDTH-2:0], divQ};
                    end else begin
                        {prodHi, prodLo} <= {mulSum, prodLo[WIDTH-1:BPC]};
                    end
`else
                    {prodHi, prodLo} <= {mulSum, prodLo[WIDTH-1:BPC]};
`endif
                end
                MD_FIX: begin
                    done <= 1'b1;
                    if (isDivReg) begin
`ifdef MULDIV_DIVIDE_EN
                        if (divZero) begin
                            lo  <= '1;
                            hi  <= rawA;
                            err <= 1'b1;
                        end else begin
                            lo <= negProd ? -prodLo : prodLo;
                            hi <= negRem ? -prodHi : prodHi;
                        end
`else
                        err <= 1'b1;
`endif
                    end else begin
                        {hi, lo} <= negProd ? -fullProd : fullProd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a
// per-cycle compare, directed literal cases, and randomized operations.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         wrHi = 1'b0;
    logic         wrLo = 1'b0;
    logic [W-1:0] wrData = '0;
    logic         busy, done, err;
    logic [W-1:0] hi, lo;

    logic         start4 = 1'b0;
    logic [1:0]   op4 = 2'b01;
    logic [W-1:0] a4 = '0;
    logic [W-1:0] b4 = '0;
    logic         zeroBit = 1'b0;
    logic [W-1:0] zeroWord = '0;
    logic         busy4, done4, err4;
    logic [W-1:0] hi4, lo4;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .wrHi(wrHi), .wrLo(wrLo), .wrData(wrData),
        .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op4), .opA(a4), .opB(b4),
        .wrHi(zeroBit), .wrLo(zeroBit), .wrData(zeroWord),
        .busy(busy4), .done(done4), .err(err4), .hi(hi4), .lo(lo4)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference result {err, hi, lo} straight from integer arithmetic.
    function automatic logic [2*W:0] reference(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [W-1:0] curHi, input logic [W-1:0] curLo);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (o == 2'b00) begin
            sp = sa * sb;
            return {1'b0, sp};
        end else if (o == 2'b01) begin
            up = ua * ub;
            return {1'b0, up};
        end else if (!DIV_EN) begin
            return {1'b1, curHi, curLo};
        end else if (b == '0) begin
            return {1'b1, a, {W{1'b1}}};
        end else if (o == 2'b10) begin
            sq = sa / sb;
            sr = sa % sb;
            return {1'b0, sr[W-1:0], sq[W-1:0]};
        end else begin
            sq = longint'(ua / ub);
            sr = longint'(ua % ub);
            return {1'b0, sr[W-1:0], sq[W-1:0]};
        end
    endfunction

    function automatic int latency(input logic [1:0] o);
        if (o[1]) return DIV_EN ? W + 1 : 1;
        return W + 1;
    endfunction

    // Model state: mRemain counts edges until the result lands (0 = idle).
    int           mRemain = 0;
    logic [W-1:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;
    logic         mDone = 1'b0, mErr = 1'b0, pErr = 1'b0;
    bit           modelValid = 1'b0;

    always @(posedge clk) begin : modelProc
        logic [2*W:0] r;
        mDone = 1'b0;
        mErr  = 1'b0;
        if (reset) begin
            mRemain    = 0;
            mHi        = '0;
            mLo        = '0;
            modelValid = 1'b1;
        end else if (mRemain == 0) begin
            if (start) begin
                r = reference(op, opA, opB, mHi, mLo);
                {pErr, pHi, pLo} = r;
                mRemain = latency(op);
            end else begin
                if (wrHi) mHi = wrData;
                if (wrLo) mLo = wrData;
            end
        end else begin
            mRemain--;
            if (mRemain == 0) begin
                mHi   = pHi;
                mLo   = pLo;
                mDone = 1'b1;
                mErr  = pErr;
            end
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("busy", busy, mRemain > 1);
            checkOutput("done", done, mDone);
            checkOutput("err", err, mErr);
            checkOutput("hi", hi, mHi);
            checkOutput("lo", lo, mLo);
        end
    end

    // Issue one op from an idle negedge and wait (bounded) for done.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int edges, output int busyCount);
        op = o;
        opA = a;
        opB = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opA = $urandom;
        opB = $urandom;
        edges = 0;
        busyCount = 0;
        while (!done && edges < 200) begin
            if (busy) busyCount++;
            @(negedge clk);
            edges++;
        end
        checkOutput("doneSeen", done, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(7))
            0: return '0;
            1: return 32'h1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e, bc, n;
        repeat (2) @(negedge clk);
        checkOutput("resetHi", hi, 0);
        checkOutput("resetLo", lo, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(2'b00, -32'sd3, 32'd5, e, bc);
        checkOutput("multLatency", e, 33);
        checkOutput("multBusyCycles", bc, 32);
        checkOutput("multHi", hi, 32'hFFFF_FFFF);
        checkOutput("multLo", lo, 32'hFFFF_FFF1);
        checkOutput("multErr", err, 0);
        @(negedge clk);

`ifdef MULDIV_DIVIDE_EN
        applyStimulus(2'b10, -32'sd7, 32'd2, e, bc);
        checkOutput("divLatency", e, 33);
        checkOutput("divLo", lo, 32'hFFFF_FFFD);
        checkOutput("divHi", hi, 32'hFFFF_FFFF);
        applyStimulus(2'b11, 32'd7, 32'd2, e, bc);
        checkOutput("divuLatency", e, 33);
        checkOutput("divuLo", lo, 3);
        checkOutput("divuHi", hi, 1);
        applyStimulus(2'b11, 32'd7, 32'd0, e, bc);
        checkOutput("divZeroLo", lo, 32'hFFFF_FFFF);
        checkOutput("divZeroHi", hi, 7);
        checkOutput("divZeroErr", err, 1);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, e, bc);
        checkOutput("divOvfLo", lo, 32'h8000_0000);
        checkOutput("divOvfHi", hi, 0);
        checkOutput("divOvfErr", err, 0);
`else
        wrHi = 1'b1;
        wrLo = 1'b1;
        wrData = 32'h0000_00AB;
        @(negedge clk);
        wrHi = 1'b0;
        wrLo = 1'b0;
        applyStimulus(2'b10, 32'd9, 32'd3, e, bc);
        checkOutput("noDivLatency", e, 1);
        checkOutput("noDivErr", err, 1);
        checkOutput("noDivHi", hi, 32'hAB);
        checkOutput("noDivLo", lo, 32'hAB);
`endif
        applyStimulus(2'b00, 32'd6, 32'd7, e, bc);
        checkOutput("mult6x7Lo", lo, 42);
        checkOutput("mult6x7Hi", hi, 0);
        @(negedge clk);

        wrHi = 1'b1;
        wrLo = 1'b1;
        wrData = 32'h5555_AAAA;
        @(negedge clk);
        wrHi = 1'b0;
        wrLo = 1'b0;
        checkOutput("mtBothHi", hi, 32'h5555_AAAA);
        checkOutput("mtBothLo", lo, 32'h5555_AAAA);

        wrHi = 1'b1;
        wrData = 32'h1234;
        @(negedge clk);
        wrHi = 1'b0;
        checkOutput("mthiHi", hi, 32'h1234);
        op = 2'b00;
        opA = 32'd3;
        opB = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        op = 2'b01;
        opA = 32'hFFFF;
        opB = 32'hFFFF;
        start = 1'b1;
        wrHi = 1'b1;
        wrLo = 1'b1;
        wrData = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        wrHi = 1'b0;
        wrLo = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("interfDone", done, 1);
        checkOutput("interfHi", hi, 0);
        checkOutput("interfLo", lo, 12);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        checkOutput("noSecondDone", n, 0);

        op = 2'b00;
        opA = 32'd100;
        opB = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetDone", done, 0);
        checkOutput("midResetErr", err, 0);
        checkOutput("midResetHi", hi, 0);
        checkOutput("midResetLo", lo, 0);
        reset = 1'b0;
        @(negedge clk);

        a4 = '1;
        b4 = '1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bpc4Latency", n, 9);
        checkOutput("bpc4Hi", hi4, 32'hFFFF_FFFE);
        checkOutput("bpc4Lo", lo4, 32'h0000_0001);
        checkOutput("bpc4Err", err4, 0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(3) == 0) begin
                wrHi = 1'($urandom_range(1));
                wrLo = 1'($urandom_range(1));
                wrData = $urandom;
                @(negedge clk);
                wrHi = 1'b0;
                wrLo = 1'b0;
            end
            op = 2'($urandom_range(3));
            opA = pick();
            opB = pick();
            start = 1'b1;
            wrHi = 1'($urandom_range(1));
            wrData = $urandom;
            @(negedge clk);
            start = 1'b0;
            wrHi = 1'b0;
            opA = $urandom;
            opB = $urandom;
            for (int c = 0; c < 200 && !done; c++) begin
                if (mRemain > 1 && $urandom_range(7) == 0) begin
                    start = 1'b1;
                    op = 2'($urandom_range(3));
                    wrHi = 1'($urandom_range(1));
                    wrLo = 1'($urandom_range(1));
                    wrData = $urandom;
                end
                @(negedge clk);
                start = 1'b0;
                wrHi = 1'b0;
                wrLo = 1'b0;
            end
            checkOutput("randDone", done, 1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
